// File: rtl/sudoku_grid_checker.sv
// sudoku_grid_checker
//   Holds a SIDE x SIDE Sudoku board (SIDE = BOX*BOX) that is written one
//   cell at a time. On request it scans the board and reports whether it is a
//   complete, valid solution. One cell is examined per clock. Rows are checked
//   first, then columns, then boxes. The scan stops on the first repeated or
//   empty cell.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous active-high reset
//   wr_en      cell write strobe (honoured only while idle)
//   wr_row     target row, 0..SIDE-1
//   wr_col     target column, 0..SIDE-1
//   wr_data    cell value, 0 = empty, 1..SIDE = digit
//   start      begin a validity scan (idle only)
//   clear      zero board and result; aborts a running scan without done
//   board      flattened grid, cell (r,c) at MSB offset (r*SIDE+c)*DW
//   busy       high while a scan runs
//   done       one-cycle pulse when a scan completes
//   valid      last scan passed; held until a write/clear/failed scan
//   err_kind   0 none, 1 row, 2 column, 3 box
//   err_index  index of the failing row, column or box
module sudoku_grid_checker #(
   parameter  int BOX  = 3,
   parameter  int DW   = 4,
   localparam int SIDE = BOX * BOX,
   localparam int RW   = $clog2(SIDE)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    wr_en,
   input  logic [RW-1:0]           wr_row,
   input  logic [RW-1:0]           wr_col,
   input  logic [DW-1:0]           wr_data,
   input  logic                    start,
   input  logic                    clear,
   output logic [SIDE*SIDE*DW-1:0] board,
   output logic                    busy,
   output logic                    done,
   output logic                    valid,
   output logic [1:0]              err_kind,
   output logic [RW-1:0]           err_index
);

   localparam int CELLS = SIDE * SIDE;
   localparam int CW    = $clog2(CELLS);

   typedef enum logic {IDLE, SCAN} state_t;

   state_t          state, state_next;
   logic [DW-1:0]   cells [CELLS];

   // Scan position: phase 0 rows, 1 columns, 2 boxes; grp is the row/column/
   // box number, pos the cell within that group.
   logic [1:0]      phase;
   logic [RW-1:0]   grp, pos;
   logic [SIDE-1:0] mask;

   logic            done_r, valid_r;
   logic [1:0]      kind_r;
   logic [RW-1:0]   index_r;

   logic [RW-1:0]   cur_row, cur_col;
   logic [CW-1:0]   cur_idx, wr_idx;
   logic [DW-1:0]   cur_val;
   logic [SIDE-1:0] cur_bit, seen;
   logic            step_fail, last_step, wr_ok;

   // Cell addressed by the current scan step.
   always_comb begin
      cur_row = '0;
      cur_col = '0;
      case (phase)
         2'd0: begin
            cur_row = grp;
            cur_col = pos;
         end
         2'd1: begin
            cur_row = pos;
            cur_col = grp;
         end
         default: begin
            cur_row = RW'((int'(grp) / BOX) * BOX + int'(pos) / BOX);
            cur_col = RW'((int'(grp) % BOX) * BOX + int'(pos) % BOX);
         end
      endcase
   end

   assign cur_idx = CW'(int'(cur_row) * SIDE + int'(cur_col));
   assign cur_val = cells[cur_idx];

   // The mask is logically cleared at the first cell of every group, so the
   // stored mask from the previous group is simply ignored there.
   always_comb begin
      seen    = (pos == '0) ? '0 : mask;
      cur_bit = '0;
      if (cur_val != '0 && cur_val <= DW'(SIDE))
         cur_bit = SIDE'(1) << (cur_val - DW'(1));
      step_fail = (cur_val == '0) || (cur_val > DW'(SIDE)) || ((seen & cur_bit) != '0);
      last_step = (phase == 2'd2) && (grp == RW'(SIDE - 1)) && (pos == RW'(SIDE - 1));
   end

   assign wr_idx = CW'(int'(wr_row) * SIDE + int'(wr_col));

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      busy       = 1'b0;
      wr_ok      = 1'b0;
      case (state)
         IDLE: begin
            wr_ok = wr_en && !clear && (int'(wr_row) < SIDE) && (int'(wr_col) < SIDE)
                    && (wr_data <= DW'(SIDE));
            if (start && !clear)
               state_next = SCAN;
         end
         SCAN: begin
            busy = 1'b1;
            if (clear || step_fail || last_step)
               state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < CELLS; i++)
            cells[i] <= '0;
         phase   <= '0;
         grp     <= '0;
         pos     <= '0;
         mask    <= '0;
         done_r  <= 1'b0;
         valid_r <= 1'b0;
         kind_r  <= '0;
         index_r <= '0;
      end else begin
         done_r <= 1'b0;
         if (clear) begin
            for (int i = 0; i < CELLS; i++)
               cells[i] <= '0;
            phase   <= '0;
            grp     <= '0;
            pos     <= '0;
            mask    <= '0;
            valid_r <= 1'b0;
            kind_r  <= '0;
            index_r <= '0;
         end else if (state == IDLE) begin
            if (wr_ok) begin
               cells[wr_idx] <= wr_data;
               valid_r       <= 1'b0;
               kind_r        <= '0;
               index_r       <= '0;
            end
         end else if (step_fail || last_step) begin
            // Scan finished either way: report and rewind all counters.
            done_r  <= 1'b1;
            valid_r <= !step_fail;
            kind_r  <= step_fail ? (phase + 2'd1) : 2'd0;
            index_r <= step_fail ? grp : '0;
            phase   <= '0;
            grp     <= '0;
            pos     <= '0;
            mask    <= '0;
         end else begin
            mask <= seen | cur_bit;
            if (pos == RW'(SIDE - 1)) begin
               pos <= '0;
               if (grp == RW'(SIDE - 1)) begin
                  grp   <= '0;
                  phase <= phase + 2'd1;
               end else begin
                  grp <= grp + RW'(1);
               end
            end else begin
               pos <= pos + RW'(1);
            end
         end
      end
   end

   // Cell 0 sits in the most significant DW bits of the flattened board.
   for (genvar i = 0; i < CELLS; i++) begin : g_board
      assign board[(CELLS - 1 - i) * DW +: DW] = cells[i];
   end

   assign done      = done_r;
   assign valid     = valid_r;
   assign err_kind  = kind_r;
   assign err_index = index_r;

endmodule

// File: tb/tb_sudoku_grid_checker.sv
// Bench for sudoku_grid_checker: a BOX=3 instance and a BOX=2/DW=3 instance.
// Scan scenarios come from a table; expected scan results are queued when a
// scan is started and compared when the design pulses done.
module tb_sudoku_grid_checker;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset;

   logic         wr_en3, start3, clear3;
   logic [3:0]   wr_row3, wr_col3, wr_data3;
   logic [323:0] board3;
   logic         busy3, done3, valid3;
   logic [1:0]   kind3;
   logic [3:0]   idx3;

   logic         wr_en2, start2, clear2;
   logic [1:0]   wr_row2, wr_col2;
   logic [2:0]   wr_data2;
   logic [47:0]  board2;
   logic         busy2, done2, valid2;
   logic [1:0]   kind2;
   logic [1:0]   idx2;

   sudoku_grid_checker #(.BOX(3), .DW(4)) dut3 (
      .clk(clk), .reset(reset), .wr_en(wr_en3), .wr_row(wr_row3), .wr_col(wr_col3),
      .wr_data(wr_data3), .start(start3), .clear(clear3), .board(board3), .busy(busy3),
      .done(done3), .valid(valid3), .err_kind(kind3), .err_index(idx3));

   sudoku_grid_checker #(.BOX(2), .DW(3)) dut2 (
      .clk(clk), .reset(reset), .wr_en(wr_en2), .wr_row(wr_row2), .wr_col(wr_col2),
      .wr_data(wr_data2), .start(start2), .clear(clear2), .board(board2), .busy(busy2),
      .done(done2), .valid(valid2), .err_kind(kind2), .err_index(idx2));

   typedef struct {
      int v;
      int k;
      int ix;
      int at;
   } exp_t;

   typedef struct {
      string name;
      int    mode;
      int    a, b, c, d;
      int    v, k, ix, lat;
   } vec_t;

   exp_t q3[$];
   exp_t q2[$];
   int   passed = 0;
   int   total  = 0;
   int   edges  = 0;
   int   m[81];
   vec_t tbl[5];

   always @(posedge clk) edges <= edges + 1;

   task automatic chk(string name, longint act, longint exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   task automatic chk_board(string name, logic [323:0] act, logic [323:0] exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   function automatic int gval(int box, int r, int c);
      return ((r * box + r / box + c) % (box * box)) + 1;
   endfunction

   // mode 0 solved, 1 set cell (a,b)=c, 2 swap (a,b)<->(c,d), 3 swap rows a,b
   task automatic build(int sel, int mode, int a, int b, int c, int d);
      int box = (sel == 3) ? 3 : 2;
      int side = box * box;
      int t;
      for (int r = 0; r < side; r++)
         for (int cc = 0; cc < side; cc++)
            m[r * side + cc] = gval(box, r, cc);
      if (mode == 1) m[a * side + b] = c;
      if (mode == 2) begin
         t = m[a * side + b];
         m[a * side + b] = m[c * side + d];
         m[c * side + d] = t;
      end
      if (mode == 3)
         for (int cc = 0; cc < side; cc++) begin
            t = m[a * side + cc];
            m[a * side + cc] = m[b * side + cc];
            m[b * side + cc] = t;
         end
   endtask

   function automatic logic [323:0] exp_board(int sel);
      int side = (sel == 3) ? 9 : 4;
      int dw = (sel == 3) ? 4 : 3;
      logic [323:0] eb = '0;
      for (int i = 0; i < side * side; i++)
         for (int b = 0; b < dw; b++)
            eb[(side * side - 1 - i) * dw + b] = 1'((m[i] >> b) & 1);
      return eb;
   endfunction

   task automatic set_in(int sel, bit we, int r, int c, int d, bit st, bit cl);
      wr_en3 = 0; wr_row3 = '0; wr_col3 = '0; wr_data3 = '0; start3 = 0; clear3 = 0;
      wr_en2 = 0; wr_row2 = '0; wr_col2 = '0; wr_data2 = '0; start2 = 0; clear2 = 0;
      if (sel == 3) begin
         wr_en3 = we; wr_row3 = 4'(r); wr_col3 = 4'(c); wr_data3 = 4'(d);
         start3 = st; clear3 = cl;
      end else if (sel == 2) begin
         wr_en2 = we; wr_row2 = 2'(r); wr_col2 = 2'(c); wr_data2 = 3'(d);
         start2 = st; clear2 = cl;
      end
   endtask

   task automatic load(int sel);
      int side = (sel == 3) ? 9 : 4;
      for (int i = 0; i < side * side; i++) begin
         @(negedge clk);
         set_in(sel, 1, i / side, i % side, m[i], 0, 0);
      end
      @(negedge clk);
      set_in(0, 0, 0, 0, 0, 0, 0);
   endtask

   // lat = number of clock edges after the start-sampling edge until done is seen
   task automatic begin_scan(int sel, int v, int k, int ix, int lat);
      exp_t e;
      @(negedge clk);
      e.v = v; e.k = k; e.ix = ix; e.at = edges + 1 + lat;
      if (sel == 3) q3.push_back(e); else q2.push_back(e);
      set_in(sel, 0, 0, 0, 0, 1, 0);
      @(negedge clk);
      set_in(0, 0, 0, 0, 0, 0, 0);
      chk("busy_after_start", (sel == 3) ? busy3 : busy2, 1);
   endtask

   task automatic wait_scan(int sel);
      for (int n = 0; n < 400; n++) begin
         if (((sel == 3) ? q3.size() : q2.size()) == 0) break;
         @(negedge clk);
      end
      if (((sel == 3) ? q3.size() : q2.size()) != 0) begin
         chk("scan_timeout", 0, 1);
         if (sel == 3) q3.delete(); else q2.delete();
      end
   endtask

   always @(negedge clk) begin : mon
      exp_t e;
      if (done3) begin
         if (q3.size() == 0) chk("done3_unexpected", 1, 0);
         else begin
            e = q3.pop_front();
            chk("done3_time", edges, e.at);
            chk("done3_valid", valid3, e.v);
            chk("done3_kind", kind3, e.k);
            chk("done3_index", idx3, e.ix);
            chk("done3_busy_low", busy3, 0);
         end
      end
      if (done2) begin
         if (q2.size() == 0) chk("done2_unexpected", 1, 0);
         else begin
            e = q2.pop_front();
            chk("done2_time", edges, e.at);
            chk("done2_valid", valid2, e.v);
            chk("done2_kind", kind2, e.k);
            chk("done2_index", idx2, e.ix);
            chk("done2_busy_low", busy2, 0);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int seen;
      tbl[0] = '{"solved",        0, 0, 0, 0, 0, 1, 0, 0, 243};
      tbl[1] = '{"swap_4_0_4_1",  2, 4, 0, 4, 1, 0, 2, 0, 89};
      tbl[2] = '{"row_swap_0_3",  3, 0, 3, 0, 0, 0, 3, 0, 166};
      tbl[3] = '{"dup_2_3",       1, 2, 3, 2, 0, 0, 1, 2, 23};
      tbl[4] = '{"cell_8_8_zero", 1, 8, 8, 0, 0, 0, 1, 8, 81};

      // Reset with every control input active: nothing may take effect.
      reset = 1'b1;
      set_in(3, 1, 0, 0, 5, 1, 0);
      wr_en2 = 1; wr_data2 = 3'd1; start2 = 1;
      repeat (3) @(negedge clk);
      chk_board("rst_board3", board3, '0);
      chk("rst_busy3", busy3, 0);
      chk("rst_done3", done3, 0);
      chk("rst_valid3", valid3, 0);
      chk("rst_kind3", kind3, 0);
      chk("rst_idx3", idx3, 0);
      chk_board("rst_board2", {276'b0, board2}, '0);
      chk("rst_busy2", busy2, 0);
      chk("rst_valid2", valid2, 0);
      reset = 1'b0;
      set_in(0, 0, 0, 0, 0, 0, 0);

      for (int i = 0; i < 5; i++) begin
         build(3, tbl[i].mode, tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].d);
         load(3);
         chk_board({"load_", tbl[i].name}, board3, exp_board(3));
         chk({"valid_after_load_", tbl[i].name}, valid3, 0);
         begin_scan(3, tbl[i].v, tbl[i].k, tbl[i].ix, tbl[i].lat);
         wait_scan(3);
         chk({"held_valid_", tbl[i].name}, valid3, tbl[i].v);
         chk({"held_kind_", tbl[i].name}, kind3, tbl[i].k);
         chk({"held_idx_", tbl[i].name}, idx3, tbl[i].ix);
      end

      // Out-of-range writes are dropped and leave the result alone.
      @(negedge clk); set_in(3, 1, 0, 0, 10, 0, 0);
      @(negedge clk); set_in(3, 1, 9, 0, 1, 0, 0);
      @(negedge clk); set_in(3, 1, 0, 9, 1, 0, 0);
      @(negedge clk); set_in(0, 0, 0, 0, 0, 0, 0);
      chk_board("dropped_writes_board", board3, exp_board(3));
      chk("dropped_writes_kind", kind3, 1);
      chk("dropped_writes_idx", idx3, 8);

      // An accepted write clears the result.
      build(3, 0, 0, 0, 0, 0);
      @(negedge clk); set_in(3, 1, 8, 8, m[80], 0, 0);
      @(negedge clk); set_in(0, 0, 0, 0, 0, 0, 0);
      chk("write_clears_kind", kind3, 0);
      chk("write_clears_idx", idx3, 0);
      chk_board("write_fix_board", board3, exp_board(3));

      // Writes and starts during a scan are ignored.
      begin_scan(3, 1, 0, 0, 243);
      repeat (5) begin
         @(negedge clk); set_in(3, 1, 0, 0, 0, 1, 0);
      end
      @(negedge clk); set_in(0, 0, 0, 0, 0, 0, 0);
      chk("busy_mid_scan", busy3, 1);
      wait_scan(3);
      chk_board("scan_write_ignored", board3, exp_board(3));
      chk("scan_pass_valid", valid3, 1);

      // Clear sampled 10 edges after start aborts without done.
      @(negedge clk); set_in(3, 0, 0, 0, 0, 1, 0);
      @(negedge clk); set_in(0, 0, 0, 0, 0, 0, 0);
      repeat (9) @(negedge clk);
      chk("busy_before_clear", busy3, 1);
      set_in(3, 0, 0, 0, 0, 0, 1);
      @(negedge clk); set_in(0, 0, 0, 0, 0, 0, 0);
      chk("clear_busy", busy3, 0);
      chk_board("clear_board", board3, '0);
      chk("clear_valid", valid3, 0);
      seen = 0;
      repeat (260) begin
         @(negedge clk);
         if (done3) seen = 1;
      end
      chk("no_done_after_clear", seen, 0);
      begin_scan(3, 0, 1, 0, 1);
      wait_scan(3);

      // Asynchronous reset in the middle of a scan.
      build(3, 0, 0, 0, 0, 0);
      load(3);
      @(negedge clk); set_in(3, 0, 0, 0, 0, 1, 0);
      @(negedge clk); set_in(0, 0, 0, 0, 0, 0, 0);
      repeat (20) @(negedge clk);
      chk("busy_before_reset", busy3, 1);
      #2 reset = 1'b1;
      #1;
      chk("async_reset_busy", busy3, 0);
      chk_board("async_reset_board", board3, '0);
      @(negedge clk);
      reset = 1'b0;
      seen = 0;
      repeat (260) begin
         @(negedge clk);
         if (done3) seen = 1;
      end
      chk("no_done_after_reset", seen, 0);

      // BOX=2, DW=3 instance.
      build(2, 0, 0, 0, 0, 0);
      load(2);
      chk_board("load4x4", {276'b0, board2}, exp_board(2));
      begin_scan(2, 1, 0, 0, 48);
      wait_scan(2);
      @(negedge clk); set_in(2, 1, 1, 1, 5, 0, 0);
      @(negedge clk); set_in(0, 0, 0, 0, 0, 0, 0);
      chk_board("drop_data5_board", {276'b0, board2}, exp_board(2));
      chk("drop_data5_valid", valid2, 1);
      @(negedge clk); set_in(2, 1, 0, 0, 2, 1, 1);
      @(negedge clk); set_in(0, 0, 0, 0, 0, 0, 0);
      chk("clear_beats_start", busy2, 0);
      chk_board("clear_idle_board", {276'b0, board2}, '0);
      chk("clear_idle_valid", valid2, 0);

      repeat (3) @(negedge clk);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/sudoku_grid_checker.md
SUDOKU_GRID_CHECKER -- requirements
Module: sudoku_grid_checker

Interface
REQ-001 SHALL have parameter BOX, default 3, giving the box edge; derived SIDE = BOX*BOX and RW = clog2(SIDE).
REQ-002 SHALL have parameter DW, default 4, giving the cell width; DW >= clog2(SIDE+1) is required.
REQ-003 SHALL use one clock; reset is asynchronous and active-high, and the ports are named clk and reset.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset  input  1  async active-high reset.
REQ-006 wr_en  input  1  cell write strobe.
REQ-007 wr_row  input  RW  target row, 0..SIDE-1.
REQ-008 wr_col  input  RW  target column, 0..SIDE-1.
REQ-009 wr_data  input  DW  cell value; 0 = empty.
REQ-010 start  input  1  begin a validity scan.
REQ-011 clear  input  1  zero the board and the result.
REQ-012 board  output  SIDE*SIDE*DW  flattened grid; cell (r,c) occupies the DW bits at MSB offset (r*SIDE+c)*DW.
REQ-013 busy  output  1  high while a scan runs.
REQ-014 done  output  1  one-cycle pulse when a scan completes.
REQ-015 valid  output  1  last scan passed; held until invalidated.
REQ-016 err_kind  output  2  failure group: 0 none, 1 row, 2 column, 3 box.
REQ-017 err_index  output  RW  index of the failing row, column or box.

Function
REQ-018 SHALL implement states IDLE and SCAN; reset enters IDLE.
REQ-019 In IDLE, wr_en SHALL write wr_data into cell (wr_row,wr_col) at the clock edge.
- The write is dropped if wr_row >= SIDE, wr_col >= SIDE or wr_data > SIDE.
REQ-020 An accepted write SHALL clear valid, err_kind and err_index to 0.
REQ-021 wr_en during SCAN SHALL be ignored; the board is stable throughout a scan.
REQ-022 start in IDLE SHALL enter SCAN and raise busy on the next cycle.
- A same-cycle accepted write commits first and is visible to the scan.
REQ-023 start during SCAN SHALL be ignored.
REQ-024 SCAN SHALL evaluate exactly one cell per cycle, in this order:
- rows 0..SIDE-1 with columns 0..SIDE-1;
- then columns 0..SIDE-1 with rows 0..SIDE-1;
- then boxes 0..SIDE-1 (box b origin = (b/BOX)*BOX, (b%BOX)*BOX), cells in row-major order within the box.
REQ-025 Each group SHALL use a SIDE-bit seen-mask, cleared at the group start.
- A cell fails if its value is 0 or its mask bit is already set; otherwise its bit is set.
REQ-026 On the first failure, the scan SHALL stop and return to IDLE.
- Result: valid=0, err_kind = current phase, err_index = current group.
REQ-027 If all 3*SIDE*SIDE steps pass, the scan SHALL return to IDLE with valid=1 and err_kind=0.
REQ-028 Timing SHALL be exact, with start sampled at edge t and step k (0-based) evaluated in cycle t+1+k:
- done pulses in cycle t+2+k after a failure at step k;
- done pulses in cycle t+1+3*SIDE*SIDE after a pass;
- busy falls in the same cycle that done rises.
REQ-029 clear SHALL take priority over start and wr_en.
- In IDLE: zero board, valid, err_kind and err_index.
- In SCAN: abort to IDLE, zero the same state, and suppress done.
REQ-030 Step, group and phase counters SHALL wrap to 0 on return to IDLE; there is no residual state between scans.

Reset
REQ-031 While reset is high, all of the following SHALL be 0 and the state SHALL be IDLE, independent of clk: board, busy, done, valid, err_kind, err_index and all counters and masks.
REQ-032 Reset asserted mid-scan SHALL abort the scan without a done pulse.

Verification
REQ-033 Reset -> every output is 0; wr_en, start and clear are ignored while reset is high.
REQ-034 BOX=3: 81 writes of a solved grid, start at t -> busy from t+1; done at t+244 with valid=1, err_kind=0.
REQ-035 Same grid, swap cells (4,0) and (4,1), start at t -> rows pass; done with err_kind=2, err_index=0, valid=0.
REQ-036 Solved grid with cell (8,8)=0, start at t -> done at t+82 with err_kind=1, err_index=8.
REQ-037 start, then clear 10 cycles later -> busy=0 on the next cycle; no done pulse; board all 0; a fresh start on the empty board fails at step 0.
REQ-038 BOX=2, DW=3: a write of wr_data=5 is dropped; a solved 4x4 grid with start at t gives done at t+49, valid=1.
